// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache front end for a fetch stage that mixes
// 16-bit and 32-bit instructions. A hit returns the instruction in the same
// cycle. A miss refills one 16-byte line from the memory controller, one word
// per beat. An instruction that straddles two lines refills line A first and
// then line B.
// INDEX_BITS must be at least 1.
module icache_fetch #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_en,
  input  logic [31:0] fetch_pc,
  output logic        inst_rdy,
  output logic [31:0] inst_out,
  output logic        ic2mc_req,
  output logic [31:0] ic2mc_addr,
  input  logic        mc2ic_rdy,
  input  logic [31:0] mc2ic_data
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  // Cache storage: valid bits are reset, tags and data are not.
  logic [LINES-1:0]    valid_r;
  logic [TAG_BITS-1:0] tag_mem_r  [LINES];
  logic [31:0]         data_mem_r [LINES][4];

  // Refill control state.
  state_t                state_r, state_s;
  logic [1:0]            cnt_r, cnt_s;
  logic [INDEX_BITS-1:0] tgt_idx_r, tgt_idx_s;
  logic [TAG_BITS-1:0]   tgt_tag_r, tgt_tag_s;
  logic                  start_s, beat_s, done_s;

  // Lookup path.
  logic [27:0]           line_a_s, line_b_s;
  logic [INDEX_BITS-1:0] idx_a_s, idx_b_s;
  logic [TAG_BITS-1:0]   tag_a_s, tag_b_s;
  logic                  hit_a_s, hit_b_s, need_b_s, hit_s;
  logic [31:0]           word_a_s;
  logic [1:0]            wsel_nx_s;
  logic [15:0]           word_a_nx_lo_s, word_b0_lo_s;
  logic [15:0]           lo_half_s, hi_half_s;
  logic                  last_half_s;
  logic                  unused_pc0_s;

  // Bit 0 of the fetch address is ignored because fetch addresses are
  // halfword aligned.
  assign unused_pc0_s = fetch_pc[0];

  // Line B is the line that holds fetch_pc+2. It differs from line A only
  // when fetch_pc points at the last halfword of a line. The 28-bit line
  // address wraps naturally from 0xFFFFFFF to 0.
  assign last_half_s = (fetch_pc[3:1] == 3'b111);
  assign line_a_s    = fetch_pc[31:4];
  assign line_b_s    = line_a_s + {27'd0, last_half_s};
  assign idx_a_s     = line_a_s[INDEX_BITS-1:0];
  assign tag_a_s     = line_a_s[27:INDEX_BITS];
  assign idx_b_s     = line_b_s[INDEX_BITS-1:0];
  assign tag_b_s     = line_b_s[27:INDEX_BITS];

  assign hit_a_s = valid_r[idx_a_s] && (tag_mem_r[idx_a_s] == tag_a_s);
  assign hit_b_s = valid_r[idx_b_s] && (tag_mem_r[idx_b_s] == tag_b_s);

  assign word_a_s       = data_mem_r[idx_a_s][fetch_pc[3:2]];
  assign wsel_nx_s      = fetch_pc[3:2] + 2'd1;
  assign word_a_nx_lo_s = data_mem_r[idx_a_s][wsel_nx_s][15:0];
  assign word_b0_lo_s   = data_mem_r[idx_b_s][2'd0][15:0];
  assign lo_half_s      = fetch_pc[1] ? word_a_s[31:16] : word_a_s[15:0];

  // A 32-bit instruction (low bits 2'b11) that starts on the last halfword
  // of a line also needs the first halfword of the next line.
  assign need_b_s = last_half_s && (lo_half_s[1:0] == 2'b11);
  assign hit_s    = hit_a_s && (!need_b_s || hit_b_s);

  // Select the upper halfword of the returned instruction.
  always_comb begin
    hi_half_s = 16'd0;
    if (need_b_s) begin
      hi_half_s = word_b0_lo_s;
    end else if (last_half_s) begin
      hi_half_s = 16'd0;
    end else if (fetch_pc[1]) begin
      hi_half_s = word_a_nx_lo_s;
    end else begin
      hi_half_s = word_a_s[31:16];
    end
  end

  assign inst_rdy   = fetch_en && hit_s && (state_r == IDLE) && rdy_in;
  assign inst_out   = {hi_half_s, lo_half_s};
  assign ic2mc_req  = (state_r == REFILL);
  assign ic2mc_addr = (state_r == REFILL) ? {tgt_tag_r, tgt_idx_r, cnt_r, 2'b00} : 32'd0;

  // Next-state logic: choose the refill target on a miss, then count beats.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    tgt_idx_s = tgt_idx_r;
    tgt_tag_s = tgt_tag_r;
    start_s   = 1'b0;
    beat_s    = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (rdy_in && fetch_en && !hit_a_s) begin
          state_s   = REFILL;
          cnt_s     = 2'd0;
          tgt_idx_s = idx_a_s;
          tgt_tag_s = tag_a_s;
          start_s   = 1'b1;
        end else if (rdy_in && fetch_en && need_b_s && !hit_b_s) begin
          state_s   = REFILL;
          cnt_s     = 2'd0;
          tgt_idx_s = idx_b_s;
          tgt_tag_s = tag_b_s;
          start_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      REFILL: begin
        if (rdy_in && mc2ic_rdy) begin
          beat_s = 1'b1;
          cnt_s  = cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = REFILL;
          end
        end else begin
          state_s = REFILL;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 2'd0;
      end
    endcase
  end

  // State register for the refill controller.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_r   <= IDLE;
      cnt_r     <= 2'd0;
      tgt_idx_r <= '0;
      tgt_tag_r <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      tgt_idx_r <= tgt_idx_s;
      tgt_tag_r <= tgt_tag_s;
    end
  end

  // Valid bits: cleared when a refill starts and set when its last beat lands.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      valid_r <= '0;
    end else if (start_s) begin
      valid_r[tgt_idx_s] <= 1'b0;
    end else if (done_s) begin
      valid_r[tgt_idx_r] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Data and tag arrays: one word per accepted beat, and the tag on the last beat.
  always_ff @(posedge clk) begin
    if (beat_s) begin
      data_mem_r[tgt_idx_r][cnt_r] <= mc2ic_data;
    end
    if (done_s) begin
      tag_mem_r[tgt_idx_r] <= tgt_tag_r;
    end
  end

endmodule
